// File: rtl/allophone_feeder.sv
// Queues host allophone codes and loads them one at a time into the Speech256 core (build option AUTO_PAUSE_EN).
// Latency: data_stb rises 2 cycles after the push into an empty FIFO when ldq=1; one strobe per ldq rise/fall.
// Backpressure: pushes while full are dropped and set sticky overflow; ldq=0 holds the queue.
module allophone_feeder #(
    parameter int         DEPTH       = 16,
    parameter int         AW          = 4,
    parameter int         ACK_TIMEOUT = 15,
    parameter logic [5:0] PAUSE_CODE  = 6'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    wr_data,
    input  logic          wr_en,
    input  logic          flush,
    input  logic          ldq,
    output logic [5:0]    data_out,
    output logic          data_stb,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          timeout,
    output logic          busy
);
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ISSUE  = 2'd1;
    localparam logic [1:0]  S_WAIT   = 2'd2;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [7:0]    timer;
    logic          push;
    logic          pop;
    logic          start_pause;
    logic [5:0]    issue_code;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign busy  = (state != S_IDLE) || !empty;
    assign push  = wr_en && !full && !flush;

`ifdef AUTO_PAUSE_EN
    logic pause_armed;
    logic pause_sel;

    // A phrase ends when the queue runs dry after a real code; the pause rides the normal ISSUE path.
    assign start_pause = empty && pause_armed;
    assign issue_code  = pause_sel ? PAUSE_CODE : mem[rd_ptr];
    assign pop         = (state == S_ISSUE) && !pause_sel && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_armed <= 1'b0;
            pause_sel   <= 1'b0;
        end else if (flush) begin
            pause_armed <= 1'b0;
            pause_sel   <= 1'b0;
        end else if (state == S_IDLE) begin
            pause_sel <= ldq && start_pause;
        end else if (state == S_ISSUE) begin
            pause_armed <= pause_sel ? 1'b0 : (mem[rd_ptr] != PAUSE_CODE);
        end
    end
`else
    assign start_pause = 1'b0;
    assign issue_code  = mem[rd_ptr];
    assign pop         = (state == S_ISSUE) && !flush;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en && full && !flush) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            data_out <= '0;
            data_stb <= 1'b0;
            timer    <= '0;
            timeout  <= 1'b0;
        end else begin
            data_stb <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ldq && (!empty || start_pause)) begin
                            state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        data_out <= issue_code;
                        data_stb <= 1'b1;
                        timer    <= 8'(ACK_TIMEOUT);
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        // Timer is counted down on the strobe cycle's successors, so expiry lands ACK_TIMEOUT cycles after data_stb.
                        if (!ldq) begin
                            state <= S_IDLE;
                        end else if (timer <= 8'd1) begin
                            timer   <= '0;
                            timeout <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_allophone_feeder.sv
// Directed bench for allophone_feeder with a queue-based reference model and a simple Speech256 ldq model.
module tb_allophone_feeder;
    localparam int         DEPTH       = 16;
    localparam int         AW          = 4;
    localparam int         ACK_TIMEOUT = 15;
    localparam logic [5:0] PAUSE_CODE  = 6'h00;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    wr_data;
    logic          wr_en;
    logic          flush;
    logic          ldq;
    logic [5:0]    data_out;
    logic          data_stb;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          timeout;
    logic          busy;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] mq[$];
    logic [5:0] got[$];
    logic       m_ovf = 1'b0;
    logic       m_armed = 1'b0;
    logic       l1 = 1'b0;
    logic       l2 = 1'b0;
    logic       core_auto = 1'b0;
    logic       ldq_hold = 1'b0;

    allophone_feeder #(
        .DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(ACK_TIMEOUT), .PAUSE_CODE(PAUSE_CODE)
    ) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .flush(flush), .ldq(ldq),
        .data_out(data_out), .data_stb(data_stb), .full(full), .empty(empty), .level(level),
        .overflow(overflow), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] c);
        wr_data = c;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_got(input int target, input int budget);
        int n;
        n = 0;
        while (got.size() < target && n < budget) begin
            step();
            n++;
        end
        chk("strobe_wait_budget", (got.size() >= target) ? 1 : 0, 1);
    endtask

    // Core model: after a strobe, ldq drops one cycle later for three cycles, then rises again.
    initial begin : core_model
        int cnt;
        cnt = 0;
        ldq = 1'b0;
        forever begin
            @(negedge clk);
            if (data_stb) cnt = 4;
            else if (cnt > 0) cnt = cnt - 1;
            ldq = core_auto ? (cnt == 0 || cnt == 4) : ldq_hold;
        end
    end

    // Reference model: host requests apply on the rising edge, strobes and flags are checked on the falling edge.
    initial begin : model
        logic [5:0] exp_code;
        forever begin
            @(posedge clk or negedge clk);
            if (clk) begin
                l2 = l1;
                l1 = ldq;
                if (!rst) begin
                    if (flush) begin
                        mq.delete();
                        m_armed = 1'b0;
                    end else if (wr_en) begin
                        if (mq.size() < DEPTH) mq.push_back(wr_data);
                        else m_ovf = 1'b1;
                    end
                end
            end else if (rst) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_armed = 1'b0;
            end else begin
                if (data_stb) begin
                    chk("ldq_high_at_issue", int'(l2), 1);
                    if (mq.size() > 0) begin
                        exp_code = mq.pop_front();
                        m_armed  = (exp_code != PAUSE_CODE);
                        chk("data_out", int'(data_out), int'(exp_code));
                    end else if (m_armed) begin
`ifdef AUTO_PAUSE_EN
                        m_armed = 1'b0;
                        chk("pause_code", int'(data_out), int'(PAUSE_CODE));
`else
                        chk("stb_with_empty_queue", int'(data_stb), 0);
`endif
                    end else begin
                        chk("stb_with_empty_queue", int'(data_stb), 0);
                    end
                    got.push_back(data_out);
                end
                chk("level", int'(level), mq.size());
                chk("full", int'(full), (mq.size() == DEPTH) ? 1 : 0);
                chk("empty", int'(empty), (mq.size() == 0) ? 1 : 0);
                chk("overflow", int'(overflow), int'(m_ovf));
                if (mq.size() > 0) chk("busy_with_data", int'(busy), 1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0;
        int n;
        rst = 1'b1; wr_en = 1'b0; flush = 1'b0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_stb", int'(data_stb), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step(); step();

        // Three codes, core acknowledging normally
        core_auto = 1'b1;
        repeat (3) step();
        n0 = got.size();
        push(6'd3); push(6'd7); push(6'd9);
        wait_got(n0 + 3, 200);
        repeat (10) step();
        chk("t1_count", got.size() - n0, 3);
        chk("t1_code0", int'(got[n0]), 3);
        chk("t1_code1", int'(got[n0+1]), 7);
        chk("t1_code2", int'(got[n0+2]), 9);
        chk("t1_level", int'(level), 0);
        chk("t1_busy", int'(busy), 0);

        // Flush with a simultaneous write
        core_auto = 1'b0; ldq_hold = 1'b0;
        repeat (3) step();
        n0 = got.size();
        for (int i = 0; i < 4; i++) push(6'h11 + 6'(i));
        chk("t4_level_before", int'(level), 4);
        flush = 1'b1; wr_en = 1'b1; wr_data = 6'h2A;
        step();
        flush = 1'b0; wr_en = 1'b0;
        chk("t4_level", int'(level), 0);
        chk("t4_empty", int'(empty), 1);
        chk("t4_overflow", int'(overflow), 0);
        ldq_hold = 1'b1;
        repeat (20) step();
        chk("t4_no_issue", got.size() - n0, 0);
        ldq_hold = 1'b0;
        repeat (3) step();

        // Overfill while the core is not ready
        n0 = got.size();
        for (int i = 0; i < DEPTH + 1; i++) push(6'h20 + 6'(i));
        chk("t2_full", int'(full), 1);
        chk("t2_level", int'(level), 16);
        chk("t2_overflow", int'(overflow), 1);
        repeat (10) step();
        chk("t2_no_issue", got.size() - n0, 0);
        core_auto = 1'b1;
        wait_got(n0 + DEPTH, 800);
        repeat (10) step();
        chk("t2_first", int'(got[n0]), 'h20);
        chk("t2_last", int'(got[n0+15]), 'h2F);
        chk("t2_drained", int'(level), 0);

        // Core never acknowledges
        core_auto = 1'b0; ldq_hold = 1'b1;
        repeat (3) step();
        chk("t3_timeout_clear", int'(timeout), 0);
        n0 = got.size();
        push(6'd5);
        n = 0;
        while (!data_stb && n < 20) begin step(); n++; end
        chk("t3_strobe_seen", int'(data_stb), 1);
        n = 0;
        while (!timeout && n < 40) begin step(); n++; end
        chk("t3_timeout", int'(timeout), 1);
        chk("t3_cycles", n, ACK_TIMEOUT);
        chk("t3_idle", int'(busy), 0);
        chk("t3_code", int'(got[n0]), 5);
        repeat (5) step();
        chk("t3_single_strobe", got.size() - n0, 1);

        // Asynchronous reset in the middle of a handshake
        push(6'h0C);
        n = 0;
        while (!data_stb && n < 20) begin step(); n++; end
        chk("t5_in_handshake", int'(data_stb), 1);
        chk("t5_ovf_sticky", int'(overflow), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_data_out", int'(data_out), 0);
        chk("t5_data_stb", int'(data_stb), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_timeout", int'(timeout), 0);
        chk("t5_overflow", int'(overflow), 0);
        chk("t5_level", int'(level), 0);
        chk("t5_empty", int'(empty), 1);
        step();
        rst = 1'b0;
        core_auto = 1'b1;
        step(); step();
        n0 = got.size();
        push(6'h15);
        wait_got(n0 + 1, 50);
        chk("t5_resume_code", int'(got[n0]), 'h15);

        // Phrase end, with or without the automatic pause
        repeat (10) step();
        n0 = got.size();
        push(6'h1B);
        wait_got(n0 + 1, 50);
        repeat (40) step();
        chk("t6_code", int'(got[n0]), 'h1B);
`ifdef AUTO_PAUSE_EN
        chk("t6_count", got.size() - n0, 2);
        chk("t6_pause", int'(got[n0+1]), int'(PAUSE_CODE));
`else
        chk("t6_count", got.size() - n0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
